// File: rtl/rf_pkg.sv
// Shared definitions for the 16x16 register set and its write-back path.
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot select for a register index.
  function automatic logic [NUM_REGS-1:0] onehot16(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dec4to16.sv
// Combinational 4-to-16 one-hot decoder with enable; all zeros when disabled.
module dec4to16
  import rf_pkg::*;
(
  input  logic                en,
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] dec
);

  assign dec = en ? onehot16(addr) : '0;

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue: buffers register writes from execute, drains one per cycle
// into the register set, and offers a forwarding lookup of pending values.
module wb_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [ADDR_W-1:0]        inAddr,
  input  logic [DATA_W-1:0]        inData,
  input  logic                     drainEn,
  output logic                     regWrite,
  output logic [(2**ADDR_W)-1:0]   decOut,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        qAddr,
  output logic                     qHit,
  output logic [DATA_W-1:0]        qData,
  output logic [$clog2(DEPTH):0]   count
);

  import rf_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_mem;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              push;
  logic              pop;
  logic [PW-1:0]     fwd_idx;

  // A full queue never accepts, even if it pops this cycle; reset blocks both sides
  // so nothing is captured or drained on a reset edge.
  assign inReady   = !reset && (count != CW'(DEPTH));
  assign push      = inValid && inReady;
  assign pop       = !reset && (count != '0) && drainEn;
  assign regWrite  = pop;
  assign writeData = regWrite ? data_mem[rd_ptr] : '0;

  dec4to16 u_dec (
    .en   (regWrite),
    .addr (addr_mem[rd_ptr]),
    .dec  (decOut)
  );

  // Pointer, occupancy and valid-bit bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      valid_mem <= '0;
    end else begin
      if (push) begin
        wr_ptr            <= wr_ptr + 1'b1;
        valid_mem[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr            <= rd_ptr + 1'b1;
        valid_mem[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; meaningful only where the valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= inAddr;
      data_mem[wr_ptr] <= inData;
    end
  end

  // Forwarding search from head to tail so the youngest match overrides older ones.
  always_comb begin
    qHit    = 1'b0;
    qData   = '0;
    fwd_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if (valid_mem[fwd_idx] && (addr_mem[fwd_idx] == qAddr)) begin
        qHit  = 1'b1;
        qData = data_mem[fwd_idx];
      end
    end
  end

endmodule
